boss_ctrl: RTL and testbench
============================

# boss_ctrl

Behaviour scheduler for the boss. It selects which player the boss targets, using aggro with hysteresis and a lock-out timer. It sequences the boss through hop volleys, wind-up, projectile bursts and cooldown, and scales timings with a monotonic HP-driven phase. It sits between the player/class aggro sources and the boss mover/projectile blocks: `target_x` and `jump_en` feed the mover, and `fire`/`fire_dir` feed the projectile spawner.

## Interface
Parameters:
- `HOPS_PER_VOLLEY`, 3, landings counted in HOP before WINDUP
- `WINDUP_TICKS`, 20, base wind-up length in frames; effective length is `WINDUP_TICKS >> phase`
- `SHOT_GAP`, 8, frames between shots within one burst
- `COOLDOWN_TICKS`, 45, frames in COOLDOWN
- `AGGRO_HYST`, 2, aggro margin required to switch target
- `LOCK_TICKS`, 60, frames after a switch during which the target cannot change
- `PHASE2_HP`, 50, HP at or below which phase becomes ≥1
- `PHASE3_HP`, 20, HP at or below which phase becomes 2

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `frame_tick` in 1: one-cycle pulse per video frame
- `game_active` in 2: 0 = not running, 1 = running, 2/3 = frozen
- `boss_hp` in 7: boss HP, 0..100
- `char_x` in 12: player 1 x position
- `player_2_x` in 12: player 2 x position
- `class_aggro` in 4: player 1 aggro
- `player_2_aggro` in 4: player 2 aggro
- `boss_x` in 12: current boss x position
- `boss_landed` in 1: one-cycle pulse from the mover when a jump ends
- `target_x` out 12: x position of the selected target (combinational mux on `target_sel`)
- `target_sel` out 1: 0 = player 1, 1 = player 2
- `jump_en` out 1: mover may start jumps
- `fire` out 1: one-cycle pulse per shot
- `fire_dir` out 1: shot direction, 0 = left, 1 = right
- `phase` out 2: 0, 1 or 2

## Operation
Target arbiter:
- Updates only on `frame_tick` while `game_active==1`.
- Aggro compares use 5-bit sums, so there is no overflow.
- If `lock_cnt != 0`: decrement `lock_cnt` and hold `target_sel`.
- Else, with `target_sel==0`: switch to 1 if `player_2_aggro >= class_aggro + AGGRO_HYST`.
- Else, with `target_sel==1`: switch to 0 if `class_aggro >= player_2_aggro + AGGRO_HYST`.
- Any switch loads `lock_cnt = LOCK_TICKS`.

Phase:
- Evaluated on `frame_tick` while `game_active==1`.
- Becomes 1 when `boss_hp <= PHASE2_HP`; becomes 2 when `boss_hp <= PHASE3_HP`.
- Never decreases, even if HP rises.

FSM states: IDLE, HOP, WINDUP, FIRE, COOLDOWN, DEAD. All transitions happen on `frame_tick` unless stated otherwise.
- **IDLE**
  - `jump_en=0`.
  - On a tick with `game_active==1`: go to HOP and set `hop_cnt=0`.
- **HOP**
  - `jump_en=1`.
  - Each `boss_landed` pulse, on any cycle, increments `hop_cnt`.
  - When `hop_cnt` reaches `HOPS_PER_VOLLEY`, on the landing cycle itself: go to WINDUP.
  - On WINDUP entry: latch `fire_dir = (target_x < boss_x) ? 0 : 1` and load `timer = WINDUP_TICKS >> phase`.
- **WINDUP**
  - `jump_en=0`.
  - If `timer==0`: go to FIRE with `shot_cnt=0` and `gap=0`. Otherwise decrement `timer`.
- **FIRE**
  - On a tick with `gap==0`: `fire` pulses high for exactly the following clock cycle (registered), `shot_cnt` increments, and `gap` loads `SHOT_GAP`.
  - On a tick with `gap!=0`: decrement `gap`.
  - After `phase+1` shots: go to COOLDOWN with `timer = COOLDOWN_TICKS`.
- **COOLDOWN**
  - `timer` decrements each tick.
  - If `timer==0`: go to HOP with `hop_cnt=0`.
- **DEAD**
  - Entered from any active state on a tick with `boss_hp==0`. This check has priority over every other transition.
  - `jump_en=0`, `fire=0`.
  - Exits only via `rst` or `game_active==0`.

`boss_landed` is ignored outside HOP.

Global rules:
- `game_active==0`: synchronous clear on the next clock to reset values (state IDLE, counters 0, `target_sel=0`, `phase=0`).
- `game_active` 2 or 3: all state frozen, `jump_en=0`, `fire=0`, `boss_landed` ignored.

## Timing
- Reset values: state IDLE, `target_sel=0`, `target_x=char_x`, `jump_en=0`, `fire=0`, `fire_dir=1`, `phase=0`, `lock_cnt=0`, all counters 0.
- `jump_en` is decoded from the registered state. It rises the cycle after the IDLE→HOP tick and falls the cycle after the landing that completes the volley.
- `fire` rises one clock after the qualifying `frame_tick` and is high for exactly one clock.
- With defaults at phase 0, the first shot comes 21 ticks after WINDUP entry: 20 decrements plus the transition tick.
- `frame_tick` and `boss_landed` in the same cycle: both are processed. A landing that completes the volley wins, and the timer is loaded fresh.
- `rst` asserted mid-burst: `fire` drops immediately (asynchronous) and no partial pulse may follow.
- `target_x` follows `char_x`/`player_2_x` combinationally, with zero latency.

## Test plan
- Reset, `game_active=1`, 3 `boss_landed` pulses → `jump_en` 1 then 0; the first `fire` comes 21 ticks after the third landing; `fire_dir=0` when `char_x=100` and `boss_x=900`.
- `phase` scaling:
  - Phase 0: 1 shot.
  - `boss_hp=50` → phase 1: wind-up 10 ticks, 2 shots 9 ticks apart.
  - `boss_hp=20` → phase 2: wind-up 5 ticks, 3 shots.
  - Setting `boss_hp=90` afterwards keeps phase 2.
- Aggro:
  - `player_2_aggro=5`, `class_aggro=4` → no switch.
  - `player_2_aggro=6` → `target_sel=1` on the next tick and `target_x=player_2_x`.
  - `class_aggro=15` within 60 ticks → no switch; the switch happens on tick 61.
- `boss_hp=0` during FIRE → DEAD on that tick, no further `fire`. Then `game_active=0` → IDLE with `phase=0`.
- `game_active=2` during COOLDOWN for 100 ticks → `timer` frozen. On return to 1, COOLDOWN resumes with its remaining count.
- `boss_landed` coincident with `frame_tick` on the 3rd landing → WINDUP entered with `timer=20`. `boss_landed` during WINDUP/COOLDOWN → `hop_cnt` unchanged.

Source files
------------

// File: rtl/boss_ctrl.sv
// boss_ctrl: boss behaviour scheduler.
// Aggro-based targeting, hop/wind-up/fire/cooldown sequencing, HP phases.
module boss_ctrl #(
    parameter int HOPS_PER_VOLLEY = 3,
    parameter int WINDUP_TICKS    = 20,
    parameter int SHOT_GAP        = 8,
    parameter int COOLDOWN_TICKS  = 45,
    parameter int AGGRO_HYST      = 2,
    parameter int LOCK_TICKS      = 60,
    parameter int PHASE2_HP       = 50,
    parameter int PHASE3_HP       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_active,
    input  logic [6:0]  boss_hp,
    input  logic [11:0] char_x,
    input  logic [11:0] player_2_x,
    input  logic [3:0]  class_aggro,
    input  logic [3:0]  player_2_aggro,
    input  logic [11:0] boss_x,
    input  logic        boss_landed,
    output logic [11:0] target_x,
    output logic        target_sel,
    output logic        jump_en,
    output logic        fire,
    output logic        fire_dir,
    output logic [1:0]  phase
);

    typedef enum logic [2:0] {
        IDLE, HOP, WINDUP, FIRE, COOLDOWN, DEAD
    } state_t;

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic [15:0] gap, gap_n;
    logic [15:0] lock_cnt, lock_n;
    logic [7:0]  hop_cnt, hop_n;
    logic [1:0]  shot_cnt, shot_n;
    logic [1:0]  phase_n;
    logic        sel_n, dir_n;
    logic        fire_q, fire_n;
    logic        run, tick, land, shoot;
    logic [4:0]  c5, p5;

    assign run  = (game_active == 2'd1);
    assign tick = run & frame_tick;
    assign land = run & boss_landed & (state == HOP);
    assign c5   = {1'b0, class_aggro};
    assign p5   = {1'b0, player_2_aggro};

    assign target_x = target_sel ? player_2_x : char_x;
    assign jump_en  = run & (state == HOP);
    assign fire     = run & fire_q;

    always_comb begin
        state_n = state;
        timer_n = timer;
        gap_n   = gap;
        lock_n  = lock_cnt;
        hop_n   = hop_cnt;
        shot_n  = shot_cnt;
        phase_n = phase;
        sel_n   = target_sel;
        dir_n   = fire_dir;
        fire_n  = 1'b0;
        shoot   = 1'b0;

        if (tick) begin
            if (lock_cnt != 16'd0) begin
                lock_n = lock_cnt - 16'd1;
            end else if (!target_sel && p5 >= c5 + 5'(AGGRO_HYST)) begin
                sel_n  = 1'b1;
                lock_n = 16'(LOCK_TICKS);
            end else if (target_sel && c5 >= p5 + 5'(AGGRO_HYST)) begin
                sel_n  = 1'b0;
                lock_n = 16'(LOCK_TICKS);
            end
            // phase only ratchets upward
            if (boss_hp <= 7'(PHASE3_HP)) begin
                phase_n = 2'd2;
            end else if (boss_hp <= 7'(PHASE2_HP) && phase == 2'd0) begin
                phase_n = 2'd1;
            end
        end

        if (tick && boss_hp == 7'd0 && state != IDLE && state != DEAD) begin
            state_n = DEAD;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state_n = HOP;
                        hop_n   = 8'd0;
                    end
                end
                HOP: begin
                    if (land) begin
                        hop_n = hop_cnt + 8'd1;
                        if (hop_n >= 8'(HOPS_PER_VOLLEY)) begin
                            state_n = WINDUP;
                            timer_n = 16'(WINDUP_TICKS >> phase);
                            dir_n   = !(target_x < boss_x);
                        end
                    end
                end
                WINDUP: begin
                    if (tick) begin
                        if (timer == 16'd0) shoot = 1'b1;
                        else timer_n = timer - 16'd1;
                    end
                end
                FIRE: begin
                    if (tick) begin
                        if (gap == 16'd0) shoot = 1'b1;
                        else gap_n = gap - 16'd1;
                    end
                end
                COOLDOWN: begin
                    if (tick) begin
                        if (timer == 16'd0) begin
                            state_n = HOP;
                            hop_n   = 8'd0;
                        end else begin
                            timer_n = timer - 16'd1;
                        end
                    end
                end
                default: ;
            endcase

            // wind-up expiry tick is also the first shot tick of the burst
            if (shoot) begin
                fire_n = 1'b1;
                shot_n = ((state == FIRE) ? shot_cnt : 2'd0) + 2'd1;
                gap_n  = 16'(SHOT_GAP);
                if (shot_n > phase) begin
                    state_n = COOLDOWN;
                    timer_n = 16'(COOLDOWN_TICKS);
                end else begin
                    state_n = FIRE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= 16'd0;
            gap        <= 16'd0;
            lock_cnt   <= 16'd0;
            hop_cnt    <= 8'd0;
            shot_cnt   <= 2'd0;
            phase      <= 2'd0;
            target_sel <= 1'b0;
            fire_dir   <= 1'b1;
            fire_q     <= 1'b0;
        end else if (game_active == 2'd0) begin
            state      <= IDLE;
            timer      <= 16'd0;
            gap        <= 16'd0;
            lock_cnt   <= 16'd0;
            hop_cnt    <= 8'd0;
            shot_cnt   <= 2'd0;
            phase      <= 2'd0;
            target_sel <= 1'b0;
            fire_dir   <= 1'b1;
            fire_q     <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            gap        <= gap_n;
            lock_cnt   <= lock_n;
            hop_cnt    <= hop_n;
            shot_cnt   <= shot_n;
            phase      <= phase_n;
            target_sel <= sel_n;
            fire_dir   <= dir_n;
            fire_q     <= fire_n;
        end
    end

endmodule

// File: tb/tb_boss_ctrl.sv
// tb_boss_ctrl: directed vector table plus hand-written sequences
// for volley timing, phases, aggro lock, freeze, death and reset.
module tb_boss_ctrl;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_active;
    logic [6:0]  boss_hp;
    logic [11:0] char_x;
    logic [11:0] player_2_x;
    logic [3:0]  class_aggro;
    logic [3:0]  player_2_aggro;
    logic [11:0] boss_x;
    logic        boss_landed;
    logic [11:0] target_x;
    logic        target_sel;
    logic        jump_en;
    logic        fire;
    logic        fire_dir;
    logic [1:0]  phase;

    int checks   = 0;
    int failures = 0;

    boss_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .game_active    (game_active),
        .boss_hp        (boss_hp),
        .char_x         (char_x),
        .player_2_x     (player_2_x),
        .class_aggro    (class_aggro),
        .player_2_aggro (player_2_aggro),
        .boss_x         (boss_x),
        .boss_landed    (boss_landed),
        .target_x       (target_x),
        .target_sel     (target_sel),
        .jump_en        (jump_en),
        .fire           (fire),
        .fire_dir       (fire_dir),
        .phase          (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ga;
        logic        ft;
        logic [3:0]  ca;
        logic [3:0]  pa;
        logic [11:0] cx;
        logic [11:0] px;
        logic [6:0]  hp;
        logic        e_sel;
        logic [11:0] e_tx;
        logic        e_jmp;
        logic [1:0]  e_ph;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // called at a negedge; returns at the next negedge
    task automatic step(input logic ft, input logic bl);
        frame_tick  = ft;
        boss_landed = bl;
        @(negedge clk);
        frame_tick  = 1'b0;
        boss_landed = 1'b0;
    endtask

    task automatic run_ticks(input int n, output int first, output int last,
                             output int cnt);
        first = 0;
        last  = 0;
        cnt   = 0;
        for (int i = 1; i <= n; i++) begin
            step(1'b1, 1'b0);
            if (fire) begin
                if (cnt == 0) first = i;
                last = i;
                cnt++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic hop3();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    initial begin
        int first, last, cnt, flag;

        vt[0]  = '{2'd0, 1'b0, 4'd4,  4'd5, 12'd100, 12'd700, 7'd100, 1'b0, 12'd100, 1'b0, 2'd0};
        vt[1]  = '{2'd1, 1'b1, 4'd4,  4'd5, 12'd100, 12'd700, 7'd100, 1'b0, 12'd100, 1'b1, 2'd0};
        vt[2]  = '{2'd1, 1'b1, 4'd4,  4'd6, 12'd100, 12'd700, 7'd100, 1'b1, 12'd700, 1'b1, 2'd0};
        vt[3]  = '{2'd1, 1'b0, 4'd4,  4'd6, 12'd123, 12'd456, 7'd100, 1'b1, 12'd456, 1'b1, 2'd0};
        vt[4]  = '{2'd2, 1'b1, 4'd15, 4'd0, 12'd123, 12'd456, 7'd50,  1'b1, 12'd456, 1'b0, 2'd0};
        vt[5]  = '{2'd1, 1'b1, 4'd15, 4'd0, 12'd123, 12'd456, 7'd50,  1'b1, 12'd456, 1'b1, 2'd1};
        vt[6]  = '{2'd1, 1'b1, 4'd15, 4'd0, 12'd123, 12'd456, 7'd90,  1'b1, 12'd456, 1'b1, 2'd1};
        vt[7]  = '{2'd1, 1'b1, 4'd15, 4'd0, 12'd123, 12'd456, 7'd20,  1'b1, 12'd456, 1'b1, 2'd2};
        vt[8]  = '{2'd1, 1'b1, 4'd15, 4'd0, 12'd123, 12'd456, 7'd100, 1'b1, 12'd456, 1'b1, 2'd2};
        vt[9]  = '{2'd0, 1'b0, 4'd15, 4'd0, 12'd123, 12'd456, 7'd100, 1'b0, 12'd123, 1'b0, 2'd0};
        vt[10] = '{2'd1, 1'b0, 4'd15, 4'd0, 12'd123, 12'd456, 7'd100, 1'b0, 12'd123, 1'b0, 2'd0};

        rst            = 1'b1;
        frame_tick     = 1'b0;
        boss_landed    = 1'b0;
        game_active    = 2'd0;
        boss_hp        = 7'd100;
        char_x         = 12'd100;
        player_2_x     = 12'd700;
        class_aggro    = 4'd0;
        player_2_aggro = 4'd0;
        boss_x         = 12'd900;
        do_reset();

        chk("reset target_sel", target_sel, 0);
        chk("reset target_x", target_x, 100);
        chk("reset jump_en", jump_en, 0);
        chk("reset fire", fire, 0);
        chk("reset fire_dir", fire_dir, 1);
        chk("reset phase", phase, 0);

        foreach (vt[i]) begin
            game_active    = vt[i].ga;
            class_aggro    = vt[i].ca;
            player_2_aggro = vt[i].pa;
            char_x         = vt[i].cx;
            player_2_x     = vt[i].px;
            boss_hp        = vt[i].hp;
            step(vt[i].ft, 1'b0);
            chk($sformatf("vec%0d target_sel", i), target_sel, vt[i].e_sel);
            chk($sformatf("vec%0d target_x", i), target_x, vt[i].e_tx);
            chk($sformatf("vec%0d jump_en", i), jump_en, vt[i].e_jmp);
            chk($sformatf("vec%0d phase", i), phase, vt[i].e_ph);
        end

        // aggro lock-out: switch back only on the 61st tick
        class_aggro    = 4'd4;
        player_2_aggro = 4'd6;
        step(1'b1, 1'b0);
        chk("lock switch to p2", target_sel, 1);
        class_aggro = 4'd15;
        flag = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0);
            if (!target_sel) flag++;
        end
        chk("lock held 60 ticks", flag, 0);
        step(1'b1, 1'b0);
        chk("lock release tick 61", target_sel, 0);
        chk("lock release target_x", target_x, 123);

        // phase 0 volley
        game_active    = 2'd0;
        do_reset();
        game_active    = 2'd1;
        boss_hp        = 7'd100;
        char_x         = 12'd100;
        boss_x         = 12'd900;
        class_aggro    = 4'd0;
        player_2_aggro = 4'd0;
        step(1'b1, 1'b0);
        chk("A jump_en in HOP", jump_en, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("A jump_en after 2 hops", jump_en, 1);
        step(1'b0, 1'b1);
        chk("A jump_en after 3 hops", jump_en, 0);
        chk("A fire_dir left", fire_dir, 0);
        run_ticks(60, first, last, cnt);
        chk("A first shot tick", first, 21);
        chk("A shot count", cnt, 1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        chk("A cooldown tick 66", jump_en, 0);
        step(1'b1, 1'b0);
        chk("A back to HOP tick 67", jump_en, 1);

        // phase 1
        boss_hp = 7'd50;
        step(1'b1, 1'b0);
        chk("B phase", phase, 1);
        hop3();
        run_ticks(40, first, last, cnt);
        chk("B first shot", first, 11);
        chk("B last shot", last, 20);
        chk("B shot count", cnt, 2);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
        chk("B still cooldown", jump_en, 0);
        step(1'b1, 1'b0);
        chk("B back to HOP", jump_en, 1);

        // phase 2, shooting right
        boss_hp = 7'd20;
        boss_x  = 12'd50;
        step(1'b1, 1'b0);
        chk("C phase", phase, 2);
        hop3();
        chk("C fire_dir right", fire_dir, 1);
        run_ticks(40, first, last, cnt);
        chk("C first shot", first, 6);
        chk("C last shot", last, 24);
        chk("C shot count", cnt, 3);
        boss_hp = 7'd90;
        step(1'b1, 1'b0);
        chk("C phase sticky", phase, 2);

        // freeze during cooldown (28 ticks remain)
        game_active = 2'd2;
        flag = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1);
            if (fire || jump_en) flag++;
        end
        chk("D frozen outputs", flag, 0);
        chk("D frozen phase", phase, 2);
        game_active = 2'd1;
        for (int i = 0; i < 28; i++) step(1'b1, 1'b0);
        chk("D cooldown resumed", jump_en, 0);
        step(1'b1, 1'b0);
        chk("D cooldown done", jump_en, 1);

        // coincident landing/tick, landings in WINDUP, async reset mid-burst
        game_active = 2'd0;
        do_reset();
        game_active = 2'd1;
        boss_hp     = 7'd100;
        boss_x      = 12'd900;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("E windup entered", jump_en, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("E landing in windup", jump_en, 0);
        run_ticks(20, first, last, cnt);
        chk("E no early shot", cnt, 0);
        step(1'b1, 1'b0);
        chk("E shot tick 21", fire, 1);
        #2 rst = 1'b1;
        #1 chk("E async fire drop", fire, 0);
        @(negedge clk);
        rst = 1'b0;
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            if (fire) flag++;
        end
        chk("E no pulse after reset", flag, 0);
        chk("E fire_dir reset", fire_dir, 1);
        chk("E jump_en reset", jump_en, 0);

        // death during FIRE
        game_active = 2'd1;
        boss_hp     = 7'd50;
        step(1'b1, 1'b0);
        hop3();
        run_ticks(11, first, last, cnt);
        chk("F first shot", first, 11);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        boss_hp = 7'd0;
        step(1'b1, 1'b0);
        chk("F dead fire", fire, 0);
        chk("F dead phase", phase, 2);
        run_ticks(30, first, last, cnt);
        chk("F no shots dead", cnt, 0);
        step(1'b0, 1'b1);
        chk("F dead jump_en", jump_en, 0);
        game_active = 2'd0;
        step(1'b0, 1'b0);
        chk("F cleared phase", phase, 0);
        game_active = 2'd1;
        boss_hp     = 7'd100;
        step(1'b1, 1'b0);
        chk("F restart HOP", jump_en, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
